// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM: fetch/decode/execute/mem/writeback.
// Define CU_DM_TIMEOUT_EN to trap data-memory acks missing for TIMEOUT_CYCLES.
module multicycle_control_unit #(
  parameter int WORDSIZE         = 64,
  parameter int INSTRUCTION_SIZE = 32,
  parameter int TIMEOUT_CYCLES   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INSTRUCTION_SIZE-1:0] instruction,
  input  logic                        im_ready,
  input  logic                        dm_ack,
  input  logic                        alu_zero,
  output logic                        cu_ir_load,
  output logic                        cu_pc_write,
  output logic                        cu_pc_sel,
  output logic [4:0]                  cu_rf_addr_a,
  output logic [4:0]                  cu_rf_addr_b,
  output logic [4:0]                  cu_rf_write_addr,
  output logic                        cu_rf_write_en,
  output logic [WORDSIZE-1:0]         cu_immediate,
  output logic                        cu_mux_0_sel,
  output logic                        cu_mux_1_sel,
  output logic                        cu_mux_2_sel,
  output logic [2:0]                  cu_alu_operation,
  output logic                        cu_dm_read_en,
  output logic                        cu_dm_write_en,
  output logic                        cu_illegal,
  output logic [2:0]                  cu_state
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    ILLEGAL   = 3'd7
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_e state_q, state_d;
  logic [INSTRUCTION_SIZE-1:0] ir_q;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       is_load, is_store, is_rtype, is_itype, is_branch;
  logic       legal, alu_rf, br_taken, tmo_hit;
  logic [2:0] alu_op;
  logic [WORDSIZE-1:0] imm;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  assign is_load = (opcode == OP_LOAD)
    && (funct3 == 3'b010 || funct3 == 3'b011);
  assign is_store = (opcode == OP_STORE)
    && (funct3 == 3'b010 || funct3 == 3'b011);
  assign is_rtype = (opcode == OP_REG) && (
    (funct3 == 3'b000
      && (funct7 == 7'b0000000 || funct7 == 7'b0100000))
    || ((funct3 == 3'b111 || funct3 == 3'b110)
      && funct7 == 7'b0000000));
  assign is_itype = (opcode == OP_IMM) && (funct3 == 3'b000
    || funct3 == 3'b111 || funct3 == 3'b110);
  assign is_branch = (opcode == OP_BRANCH)
    && (funct3 == 3'b000 || funct3 == 3'b001);

  assign legal = is_load | is_store | is_rtype
    | is_itype | is_branch;
  assign alu_rf = is_rtype | is_itype;
  // beq takes on zero, bne on non-zero
  assign br_taken = (funct3 == 3'b000) ? alu_zero : ~alu_zero;

  always_comb begin
    alu_op = 3'b000;
    unique case (1'b1)
      is_branch:                      alu_op = 3'b001;
      alu_rf && funct3 == 3'b111:     alu_op = 3'b010;
      alu_rf && funct3 == 3'b110:     alu_op = 3'b011;
      is_rtype && funct3 == 3'b000
        && funct7[5]:                 alu_op = 3'b001;
      default:                        alu_op = 3'b000;
    endcase
  end

  always_comb begin
    imm = '0;
    unique case (1'b1)
      opcode == OP_LOAD || opcode == OP_IMM:
        imm = {{(WORDSIZE-12){ir_q[31]}}, ir_q[31:20]};
      opcode == OP_STORE:
        imm = {{(WORDSIZE-12){ir_q[31]}},
               ir_q[31:25], ir_q[11:7]};
      opcode == OP_BRANCH:
        imm = {{(WORDSIZE-13){ir_q[31]}}, ir_q[31],
               ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      default: imm = '0;
    endcase
  end

`ifdef CU_DM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == EXECUTE)
      tmo_d = '0;
    else if (state_q == MEM && !dm_ack && !tmo_hit)
      tmo_d = tmo_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:
        if (im_ready) state_d = DECODE;
      DECODE:
        state_d = legal ? EXECUTE : ILLEGAL;
      EXECUTE:
        if (is_branch)
          state_d = FETCH;
        else if (is_load || is_store)
          state_d = MEM;
        else
          state_d = WRITEBACK;
      MEM:
        if (dm_ack)
          state_d = is_load ? WRITEBACK : FETCH;
        else if (tmo_hit)
          state_d = ILLEGAL;
      WRITEBACK:
        state_d = FETCH;
      ILLEGAL:
        state_d = ILLEGAL;
      default:
        state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (cu_ir_load) ir_q <= instruction;
    end
  end

  always_comb begin
    cu_ir_load       = 1'b0;
    cu_pc_write      = 1'b0;
    cu_pc_sel        = 1'b0;
    cu_rf_addr_a     = '0;
    cu_rf_addr_b     = '0;
    cu_rf_write_addr = '0;
    cu_rf_write_en   = 1'b0;
    cu_immediate     = '0;
    cu_mux_0_sel     = 1'b0;
    cu_mux_1_sel     = 1'b0;
    cu_mux_2_sel     = 1'b0;
    cu_alu_operation = 3'b000;
    cu_dm_read_en    = 1'b0;
    cu_dm_write_en   = 1'b0;
    cu_illegal       = 1'b0;
    cu_state         = state_q;
    unique case (state_q)
      FETCH:   cu_ir_load = im_ready;
      ILLEGAL: cu_illegal = 1'b1;
      default: begin
        cu_rf_addr_a     = ir_q[19:15];
        cu_rf_addr_b     = ir_q[24:20];
        cu_rf_write_addr = ir_q[11:7];
        cu_immediate     = imm;
        unique case (state_q)
          EXECUTE: begin
            cu_alu_operation = alu_op;
            cu_mux_1_sel     = is_rtype | is_branch;
            cu_pc_write      = is_branch;
            cu_pc_sel        = is_branch & br_taken;
          end
          MEM: begin
            cu_dm_read_en  = is_load;
            cu_dm_write_en = is_store;
            cu_pc_write    = is_store & dm_ack;
          end
          WRITEBACK: begin
            cu_alu_operation = alu_op;
            cu_mux_1_sel     = is_rtype;
            cu_mux_2_sel     = is_load;
            cu_rf_write_en   = (ir_q[11:7] != 5'd0);
            cu_pc_write      = 1'b1;
          end
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: phase-driven reference model
// compared every cycle, plus hand-computed spot values.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = '0;
  logic        im_ready = 1'b0;
  logic        dm_ack = 1'b0;
  logic        alu_zero = 1'b0;

  logic        cu_ir_load, cu_pc_write, cu_pc_sel;
  logic [4:0]  cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr;
  logic        cu_rf_write_en;
  logic [63:0] cu_immediate;
  logic        cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel;
  logic [2:0]  cu_alu_operation;
  logic        cu_dm_read_en, cu_dm_write_en, cu_illegal;
  logic [2:0]  cu_state;

  multicycle_control_unit #(
    .WORDSIZE(64), .INSTRUCTION_SIZE(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .instruction(instruction),
    .im_ready(im_ready), .dm_ack(dm_ack), .alu_zero(alu_zero),
    .cu_ir_load(cu_ir_load), .cu_pc_write(cu_pc_write),
    .cu_pc_sel(cu_pc_sel), .cu_rf_addr_a(cu_rf_addr_a),
    .cu_rf_addr_b(cu_rf_addr_b),
    .cu_rf_write_addr(cu_rf_write_addr),
    .cu_rf_write_en(cu_rf_write_en),
    .cu_immediate(cu_immediate), .cu_mux_0_sel(cu_mux_0_sel),
    .cu_mux_1_sel(cu_mux_1_sel), .cu_mux_2_sel(cu_mux_2_sel),
    .cu_alu_operation(cu_alu_operation),
    .cu_dm_read_en(cu_dm_read_en),
    .cu_dm_write_en(cu_dm_write_en),
    .cu_illegal(cu_illegal), .cu_state(cu_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ir_load, pc_write, pc_sel;
    logic [4:0]  a, b, wa;
    logic        we;
    logic [63:0] imm;
    logic        m0, m1, m2;
    logic [2:0]  op;
    logic        rd, wr, ill;
    logic [2:0]  st;
  } outs_t;

  typedef enum {P_F, P_D, P_E, P_M, P_W, P_I} ph_e;

  outs_t       act, exp_o;
  int          checks = 0;
  int          passed = 0;
  bit          chk_en = 1'b0;
  int          cyc = 0;
  logic [31:0] cur_ir = '0;

  assign act = {cu_ir_load, cu_pc_write, cu_pc_sel,
    cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr,
    cu_rf_write_en, cu_immediate, cu_mux_0_sel,
    cu_mux_1_sel, cu_mux_2_sel, cu_alu_operation,
    cu_dm_read_en, cu_dm_write_en, cu_illegal, cu_state};

  function automatic outs_t model(input ph_e p,
      input logic [31:0] ir, input logic imr,
      input logic ack, input logic z);
    outs_t o;
    logic [6:0] opc, f7;
    logic [2:0] f3, alu;
    logic ld, sto, r, i, br;
    o   = '0;
    opc = ir[6:0];
    f3  = ir[14:12];
    f7  = ir[31:25];
    ld  = opc == 7'h03 && (f3 == 2 || f3 == 3);
    sto = opc == 7'h23 && (f3 == 2 || f3 == 3);
    r   = opc == 7'h33 && ((f3 == 0 && (f7 == 0 || f7 == 7'h20))
          || ((f3 == 7 || f3 == 6) && f7 == 0));
    i   = opc == 7'h13 && (f3 == 0 || f3 == 7 || f3 == 6);
    br  = opc == 7'h63 && (f3 == 0 || f3 == 1);
    if (br) alu = 3'd1;
    else if ((r || i) && f3 == 7) alu = 3'd2;
    else if ((r || i) && f3 == 6) alu = 3'd3;
    else if (r && f7 == 7'h20) alu = 3'd1;
    else alu = 3'd0;
    case (p)
      P_F: o.ir_load = imr;
      P_I: begin o.ill = 1'b1; o.st = 3'd7; end
      default: begin
        o.a  = ir[19:15];
        o.b  = ir[24:20];
        o.wa = ir[11:7];
        if (opc == 7'h03 || opc == 7'h13)
          o.imm = {{52{ir[31]}}, ir[31:20]};
        else if (opc == 7'h23)
          o.imm = {{52{ir[31]}}, ir[31:25], ir[11:7]};
        else if (opc == 7'h63)
          o.imm = {{51{ir[31]}}, ir[31], ir[7], ir[30:25],
                   ir[11:8], 1'b0};
        case (p)
          P_D: o.st = 3'd1;
          P_E: begin
            o.st = 3'd2;
            o.op = alu;
            o.m1 = r || br;
            o.pc_write = br;
            o.pc_sel = br && ((f3 == 0) ? z : !z);
          end
          P_M: begin
            o.st = 3'd3;
            o.rd = ld;
            o.wr = sto;
            o.pc_write = sto && ack;
          end
          default: begin
            o.st = 3'd4;
            o.op = alu;
            o.m1 = r;
            o.m2 = ld;
            o.we = ir[11:7] != 0;
            o.pc_write = 1'b1;
          end
        endcase
      end
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      checks++;
      if (act === exp_o) passed++;
      else $display("FAIL cycle_outputs cyc=%0d got=%h want=%h",
                    cyc, act, exp_o);
    end
  end

  task automatic lit(input string nm, input logic [127:0] a,
      input logic [127:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s got=%0h want=%0h", nm, a, e);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic step(input ph_e p, input logic [31:0] bus,
      input logic imr, input logic ack, input logic z,
      input logic r);
    @(posedge clk);
    #1;
    instruction = bus;
    im_ready    = imr;
    dm_ack      = ack;
    alu_zero    = z;
    rst         = r;
    exp_o       = model(p, cur_ir, imr, ack, z);
    chk_en      = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ins);
    step(P_F, $urandom, 1'b0, rb(), rb(), 1'b0);
    step(P_F, ins, 1'b1, rb(), rb(), 1'b0);
    cur_ir = ins;
  endtask

  task automatic dec();
    step(P_D, $urandom, rb(), rb(), rb(), 1'b0);
  endtask

  task automatic exe(input logic z);
    step(P_E, $urandom, rb(), rb(), z, 1'b0);
  endtask

  task automatic mem(input logic ack);
    step(P_M, $urandom, rb(), ack, rb(), 1'b0);
  endtask

  task automatic wb();
    step(P_W, $urandom, rb(), rb(), rb(), 1'b0);
  endtask

  task automatic ill();
    step(P_I, $urandom, rb(), rb(), rb(), 1'b0);
  endtask

  task automatic rst_now(input ph_e p);
    step(p, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_AND  = 32'h0020F3B3;
  localparam logic [31:0] I_ADDI = 32'hFFF00293;
  localparam logic [31:0] I_ORI0 = 32'h0050E013;
  localparam logic [31:0] I_LW   = 32'h00812303;
  localparam logic [31:0] I_SW   = 32'h00612623;
  localparam logic [31:0] I_BEQ  = 32'hFE208CE3;
  localparam logic [31:0] I_BNE  = 32'hFE209CE3;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_MUL  = 32'h022081B3;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    step(P_F, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("reset_all_zero", act, 0);
    lit("reset_state", cu_state, 0);

    fetch(I_ADD); dec(); exe(1'b0); wb();
    lit("add_we", cu_rf_write_en, 1);
    lit("add_wa", cu_rf_write_addr, 3);
    lit("add_op", cu_alu_operation, 0);
    lit("add_m1", cu_mux_1_sel, 1);
    lit("add_pcw", cu_pc_write, 1);
    lit("add_state", cu_state, 4);

    fetch(I_SUB); dec(); exe(1'b0);
    lit("sub_op_ex", cu_alu_operation, 1);
    wb();
    lit("sub_op_wb", cu_alu_operation, 1);

    fetch(I_AND); dec(); exe(1'b1);
    lit("and_op", cu_alu_operation, 2);
    wb();

    fetch(I_ADDI); dec();
    lit("addi_imm", cu_immediate, 64'hFFFF_FFFF_FFFF_FFFF);
    exe(1'b0);
    lit("addi_m1", cu_mux_1_sel, 0);
    wb();
    lit("addi_wa", cu_rf_write_addr, 5);
    lit("addi_we", cu_rf_write_en, 1);

    fetch(I_ORI0); dec(); exe(1'b0);
    lit("ori_op", cu_alu_operation, 3);
    wb();
    lit("rd0_no_write", cu_rf_write_en, 0);

    fetch(I_LW); dec(); exe(rb());
    lit("lw_imm", cu_immediate, 8);
    mem(1'b0);
    lit("lw_rd_en", cu_dm_read_en, 1);
    mem(1'b0); mem(1'b1);
    lit("lw_rd_ack", cu_dm_read_en, 1);
    wb();
    lit("lw_m2", cu_mux_2_sel, 1);
    lit("lw_we", cu_rf_write_en, 1);
    lit("lw_wa", cu_rf_write_addr, 6);

    fetch(I_SW); dec(); exe(rb());
    lit("sw_imm", cu_immediate, 12);
    mem(1'b0);
    lit("sw_pcw_wait", cu_pc_write, 0);
    mem(1'b1);
    lit("sw_wr_en", cu_dm_write_en, 1);
    lit("sw_pcw_ack", cu_pc_write, 1);
    lit("sw_no_we", cu_rf_write_en, 0);

    fetch(I_BEQ); dec();
    lit("beq_imm", cu_immediate, 64'hFFFF_FFFF_FFFF_FFF8);
    exe(1'b1);
    lit("beq_taken", cu_pc_sel, 1);
    lit("beq_pcw", cu_pc_write, 1);
    fetch(I_BEQ); dec(); exe(1'b0);
    lit("beq_not_taken", cu_pc_sel, 0);
    fetch(I_BNE); dec(); exe(1'b0);
    lit("bne_taken", cu_pc_sel, 1);

    fetch(I_LW); dec(); exe(1'b0); mem(1'b0);
    rst_now(P_M);
    cur_ir = '0;
    step(P_F, $urandom, 1'b0, 1'b1, 1'b1, 1'b0);
    lit("rst_mid_mem_zero", act, 0);
    fetch(I_ADD); dec(); exe(1'b0); wb();

`ifdef CU_DM_TIMEOUT_EN
    fetch(I_LW); dec(); exe(1'b0);
    repeat (15) mem(1'b0);
    mem(1'b1);
    wb();
    lit("ack_at_limit_wb", cu_state, 4);
    fetch(I_LW); dec(); exe(1'b0);
    repeat (16) mem(1'b0);
    ill();
    lit("timeout_illegal", cu_illegal, 1);
    lit("timeout_state", cu_state, 7);
    rst_now(P_I);
    cur_ir = '0;
`else
    fetch(I_LW); dec(); exe(1'b0);
    repeat (20) mem(1'b0);
    mem(1'b1);
    lit("long_wait_rd", cu_dm_read_en, 1);
    wb();
`endif

    fetch(I_BAD); dec();
    repeat (20) ill();
    lit("bad_illegal", cu_illegal, 1);
    lit("bad_state", cu_state, 7);
    rst_now(P_I);
    cur_ir = '0;
    step(P_F, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("after_illegal_zero", act, 0);

    fetch(I_MUL); dec(); ill(); ill();
    rst_now(P_I);
    cur_ir = '0;
    fetch(I_SUB); dec(); exe(1'b0); wb();

    chk_en = 1'b0;
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
